// File: rtl/user_locked_regbank_if.sv
// -----------------------------------------------------------------------------
// user_locked_regbank_if
// Request/response bundle for the user-locked register bank.
//
// Master drives : usr_id, addr, wr_en, wr_data, lock_req, unlock_req,
//                 rd_addr, viol_clr
// Slave drives  : rd_data, locked, viol, viol_cnt
//
// AW follows the bank: max(1, clog2(NUM_REGS)).
// -----------------------------------------------------------------------------
interface user_locked_regbank_if #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int ID_W     = 2
);
   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [ID_W-1:0]     usr_id;
   logic [AW-1:0]       addr;
   logic                wr_en;
   logic [DATA_W-1:0]   wr_data;
   logic                lock_req;
   logic                unlock_req;
   logic [AW-1:0]       rd_addr;
   logic [DATA_W-1:0]   rd_data;
   logic [NUM_REGS-1:0] locked;
   logic                viol;
   logic                viol_clr;
   logic [7:0]          viol_cnt;

   modport master (
      output usr_id, addr, wr_en, wr_data, lock_req, unlock_req, rd_addr, viol_clr,
      input  rd_data, locked, viol, viol_cnt
   );

   modport slave (
      input  usr_id, addr, wr_en, wr_data, lock_req, unlock_req, rd_addr, viol_clr,
      output rd_data, locked, viol, viol_cnt
   );
endinterface

// File: rtl/user_locked_regbank.sv
// -----------------------------------------------------------------------------
// user_locked_regbank
// Bank of NUM_REGS registers, each guarded by an OPEN/LOCKED state machine
// with an owner ID. Writes are allowed from PRIV_ID while OPEN and from the
// owner while LOCKED. Rejected requests raise a one-cycle viol pulse.
//
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - user_locked_regbank_if.slave (requests in, read data/status out)
//
// Optional feature: define ULR_VIOL_CNT_EN to enable the saturating 8-bit
// violation counter (cleared by viol_clr from PRIV_ID). Without it, viol_cnt
// is tied to 0 and viol_clr is ignored.
// -----------------------------------------------------------------------------
module user_locked_regbank #(
   parameter int              DATA_W   = 8,
   parameter int              NUM_REGS = 4,
   parameter int              ID_W     = 2,
   parameter logic [ID_W-1:0] PRIV_ID  = ID_W'(2)
) (
   input logic                   clk,
   input logic                   rst_n,
   user_locked_regbank_if.slave  bus
);
   localparam int AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   // Read array is padded to the full address space so out-of-range
   // addresses land on hard-wired zero slots.
   localparam int SLOTS = 1 << AW;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } reg_state_t;

   logic                usr_priv;
   logic [SLOTS-1:0]    wr_ok;
   logic [SLOTS-1:0]    lock_ok;
   logic [SLOTS-1:0]    unlock_ok;
   logic [NUM_REGS-1:0] locked_vec;
   logic [DATA_W-1:0]   data_arr [SLOTS];
   logic                reject;

   logic [DATA_W-1:0]   rd_data_q;
   logic                viol_q;

   assign usr_priv = (bus.usr_id == PRIV_ID);

   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_slot
         if (gi < NUM_REGS) begin : g_reg
            reg_state_t        state_q, state_d;
            logic [ID_W-1:0]   owner_q, owner_d;
            logic [DATA_W-1:0] data_q, data_d;
            logic              hit;
            logic              is_owner;

            assign hit      = (bus.addr == AW'(gi));
            assign is_owner = (bus.usr_id == owner_q);

            // Write permission is judged on the current state, so a write
            // combined with lock/unlock sees the pre-transition state.
            assign wr_ok[gi]     = hit & bus.wr_en &
                                   ((state_q == ST_OPEN) ? usr_priv : is_owner);
            assign lock_ok[gi]   = hit & bus.lock_req & ~bus.unlock_req &
                                   (state_q == ST_OPEN);
            assign unlock_ok[gi] = hit & bus.unlock_req & ~bus.lock_req &
                                   (state_q == ST_LOCKED) & (is_owner | usr_priv);

            always_comb begin
               state_d = state_q;
               owner_d = owner_q;
               data_d  = data_q;
               if (wr_ok[gi]) data_d = bus.wr_data;
               case (state_q)
                  ST_OPEN: begin
                     if (lock_ok[gi]) begin
                        state_d = ST_LOCKED;
                        owner_d = bus.usr_id;
                     end
                  end
                  ST_LOCKED: begin
                     // Owner is retained on unlock.
                     if (unlock_ok[gi]) state_d = ST_OPEN;
                  end
                  default: state_d = ST_OPEN;
               endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  state_q <= ST_OPEN;
                  owner_q <= '0;
                  data_q  <= '0;
               end else begin
                  state_q <= state_d;
                  owner_q <= owner_d;
                  data_q  <= data_d;
               end
            end

            assign data_arr[gi]   = data_q;
            assign locked_vec[gi] = (state_q == ST_LOCKED);
         end else begin : g_pad
            assign wr_ok[gi]     = 1'b0;
            assign lock_ok[gi]   = 1'b0;
            assign unlock_ok[gi] = 1'b0;
            assign data_arr[gi]  = '0;
         end
      end
   endgenerate

   // Any asserted request that no register accepted is a violation; this
   // covers out-of-range addresses and simultaneous lock/unlock.
   assign reject = (bus.wr_en      & ~(|wr_ok))   |
                   (bus.lock_req   & ~(|lock_ok)) |
                   (bus.unlock_req & ~(|unlock_ok));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
         viol_q    <= 1'b0;
      end else begin
         rd_data_q <= data_arr[bus.rd_addr];
         viol_q    <= reject;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.locked  = locked_vec;
   assign bus.viol    = viol_q;

`ifdef ULR_VIOL_CNT_EN
   logic [7:0] viol_cnt_q, viol_cnt_d;

   // Increment lands on the same edge that raises viol; a privileged clear
   // wins over a concurrent increment.
   always_comb begin
      viol_cnt_d = viol_cnt_q;
      if (bus.viol_clr && usr_priv) begin
         viol_cnt_d = '0;
      end else if (reject && (viol_cnt_q != 8'hFF)) begin
         viol_cnt_d = viol_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) viol_cnt_q <= '0;
      else        viol_cnt_q <= viol_cnt_d;
   end

   assign bus.viol_cnt = viol_cnt_q;
`else
   logic unused_viol_clr;
   assign unused_viol_clr = bus.viol_clr;
   assign bus.viol_cnt    = 8'h00;
`endif

endmodule
